// File: rtl/reg_array_reader_pkg.sv
// Shared types and default sizing for the register-array read-out engine.
package reg_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rar_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/reg_array_reader_if.sv
// Control, array read port and output stream of the register-array reader.
interface reg_array_reader_if
    import reg_array_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
);
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/reg_array_reader_fifo2.sv
// Two-entry FIFO whose head falls through from the push port when empty,
// so a returning read word is visible in the same cycle it arrives.
module fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         head_valid,
    output logic [W-1:0] head_data
);
    logic [W-1:0] mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   occ_r;
    logic         empty_s;
    logic         bypass_s;
    logic         wr_s;
    logic         rd_s;

    assign empty_s    = (occ_r == 2'd0);
    assign bypass_s   = empty_s && push;
    // A word that bypasses and is popped in the same cycle never needs storing.
    assign wr_s       = push && !(bypass_s && pop);
    assign rd_s       = pop && !empty_s;
    assign head_valid = !empty_s || push;
    assign head_data  = bypass_s ? push_data : mem_r[rd_ptr_r];
    assign occ        = occ_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (rd_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({wr_s, rd_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    fifo2_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .occ  (occ_r)
    );
endmodule

// Overflow watchdog; the issue rule upstream must keep this from ever firing.
module fifo2_chk (
    input logic       clk,
    input logic       rst,
    input logic       push,
    input logic [1:0] occ
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && occ == 2'd2))
        else $error("fifo2: push while full");
endmodule

// File: rtl/reg_array_reader.sv
// Streams array entries 0..DEPTH-1 from a 1-cycle-latency read port onto a
// valid/ready output, throttling issue so the 2-entry buffer never overflows.
module reg_array_reader
    import reg_array_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    reg_array_reader_if.master  bus
);
    rar_state_t        state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              done_r;

    logic [1:0]        occ_s;
    logic              head_valid_s;
    logic [DATA_W:0]   head_s;
    logic              head_last_s;
    logic              pop_s;
    logic [2:0]        room_s;
    logic              last_addr_s;
    logic              rd_en_s;

    assign head_last_s = head_s[DATA_W];
    assign pop_s       = head_valid_s && bus.out_ready;
    // Words held or on their way back, after this cycle's pop.
    assign room_s      = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign last_addr_s = (cnt_r == ADDR_W'(DEPTH - 1));
    assign rd_en_s     = (state_r == READ) && (room_s < 3'd2);

    // Pass sequencing, issue counter, in-flight tracking and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= {ADDR_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            inflight_r      <= rd_en_s;
            inflight_last_r <= rd_en_s && last_addr_s;
            done_r          <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= {ADDR_W{1'b0}};
                    if (bus.start) begin
                        state_r <= READ;
                    end
                end
                READ: begin
                    // Counter holds on the final address so it never wraps.
                    if (rd_en_s) begin
                        if (last_addr_s) begin
                            state_r <= DRAIN;
                        end else begin
                            cnt_r <= cnt_r + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop_s && head_last_s) begin
                        done_r  <= 1'b1;
                        cnt_r   <= {ADDR_W{1'b0}};
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_r),
        .push_data  ({inflight_last_r, bus.rd_data}),
        .pop        (pop_s),
        .occ        (occ_s),
        .head_valid (head_valid_s),
        .head_data  (head_s)
    );

    assign bus.rd_en     = rd_en_s;
    assign bus.rd_addr   = cnt_r;
    assign bus.out_valid = head_valid_s;
    assign bus.out_data  = head_s[DATA_W-1:0];
    assign bus.out_last  = head_last_s;
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
endmodule
